// File: rtl/cu_fsm_mc.sv
// ---------------------------------------------------------------------------
// cu_fsm_mc - multicycle control-unit state machine for the RISC-V core.
//
// Sequences INIT -> FETCH -> EXEC [-> WB] [-> INTR] -> FETCH around the
// combinational decoder. FETCH and WB each last MEM_LAT cycles. Interrupts
// are latched into a sticky pending register and taken only at an
// instruction boundary. The lowest pending index wins.
//
// Optional feature macro: CU_IRQ_EDGE_EN
//   defined   - a pending bit sets only on a rising edge of its IRQ line
//   undefined - level capture; no IRQ delay register is instantiated
//
// Parameters
//   MEM_LAT  memory read latency for fetch / load data, 1..15
//   NUM_IRQ  number of interrupt request lines, 1..8
//   IDW      width of IRQ_ID
//
// Ports
//   CLK, RST_N           clock, asynchronous active-low reset
//   CU_OPCODE, FUNC3     instruction fields used by the EXEC strobes
//   IRQ, MIE             level interrupt requests, global enable
//   RESET_OUT            resets the PC and downstream registers
//   PC_WRITE, REG_WRITE  PC load, register-file write
//   MEM_RDEN1            instruction-port read enable
//   MEM_RDEN2, MEM_WE2   data-port read / write enables
//   CSR_WE, MRET_EXEC    CSR write enable, MRET pulse
//   INT_TAKEN            interrupt entry (one cycle)
//   IRQ_ACK, IRQ_ID      one-hot acknowledge and index of serviced source
//   ILLEGAL              unknown-opcode pulse in EXEC
// ---------------------------------------------------------------------------
module cu_fsm_mc #(
   parameter int MEM_LAT = 1,
   parameter int NUM_IRQ = 1,
   parameter int IDW     = $clog2(NUM_IRQ > 1 ? NUM_IRQ : 2)
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [6:0]         CU_OPCODE,
   input  logic [2:0]         FUNC3,
   input  logic [NUM_IRQ-1:0] IRQ,
   input  logic               MIE,
   output logic               RESET_OUT,
   output logic               PC_WRITE,
   output logic               REG_WRITE,
   output logic               MEM_RDEN1,
   output logic               MEM_RDEN2,
   output logic               MEM_WE2,
   output logic               CSR_WE,
   output logic               MRET_EXEC,
   output logic               INT_TAKEN,
   output logic [NUM_IRQ-1:0] IRQ_ACK,
   output logic [IDW-1:0]     IRQ_ID,
   output logic               ILLEGAL
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // terminal count of the shared fetch / writeback wait counter
   localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_INTR
   } state_t;

   state_t             state, state_nxt;
   logic [3:0]         cnt, cnt_nxt;
   logic [NUM_IRQ-1:0] pend, pend_set;
   logic [IDW-1:0]     win_id;
   logic               cnt_last, irq_go;

   assign cnt_last = (cnt == CNT_LAST);
   assign irq_go   = MIE && (|pend);

   // ---------------- interrupt capture ----------------
`ifdef CU_IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] irq_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) irq_q <= '0;
      else        irq_q <= IRQ;
   end

   assign pend_set = IRQ & ~irq_q;
`else
   assign pend_set = IRQ;
`endif

   // set wins over the acknowledge, so a still-asserted source re-pends
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) pend <= '0;
      else        pend <= (pend & ~IRQ_ACK) | pend_set;
   end

   // lowest pending index wins: scan downwards so the last hit is the lowest
   always_comb begin
      win_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (pend[i]) win_id = IDW'(i);
   end

   // ---------------- state register ----------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // ---------------- next state ----------------
   // the counter returns to 0 on every state exit and whenever it is not
   // actively counting a fetch or writeback
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         ST_INIT:  state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (cnt_last) state_nxt = ST_EXEC;
            else          cnt_nxt   = cnt + 4'd1;
         end
         ST_EXEC: begin
            if (CU_OPCODE == OPC_LOAD) state_nxt = ST_WB;
            else                       state_nxt = irq_go ? ST_INTR : ST_FETCH;
         end
         ST_WB: begin
            if (cnt_last) state_nxt = irq_go ? ST_INTR : ST_FETCH;
            else          cnt_nxt   = cnt + 4'd1;
         end
         ST_INTR:  state_nxt = ST_FETCH;
         default:  state_nxt = ST_INIT;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      RESET_OUT = 1'b0;
      PC_WRITE  = 1'b0;
      REG_WRITE = 1'b0;
      MEM_RDEN1 = 1'b0;
      MEM_RDEN2 = 1'b0;
      MEM_WE2   = 1'b0;
      CSR_WE    = 1'b0;
      MRET_EXEC = 1'b0;
      INT_TAKEN = 1'b0;
      IRQ_ACK   = '0;
      IRQ_ID    = '0;
      ILLEGAL   = 1'b0;
      case (state)
         ST_INIT:  RESET_OUT = 1'b1;
         ST_FETCH: MEM_RDEN1 = 1'b1;
         ST_EXEC: begin
            case (CU_OPCODE)
               OPC_LOAD:   MEM_RDEN2 = 1'b1;
               OPC_STORE: begin
                  MEM_WE2  = 1'b1;
                  PC_WRITE = 1'b1;
               end
               OPC_BRANCH: PC_WRITE = 1'b1;
               OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
                  REG_WRITE = 1'b1;
                  PC_WRITE  = 1'b1;
               end
               OPC_SYSTEM: begin
                  PC_WRITE = 1'b1;
                  case (FUNC3)
                     3'd0:    MRET_EXEC = 1'b1;
                     3'd4:    ;
                     default: begin
                        CSR_WE    = 1'b1;
                        REG_WRITE = 1'b1;
                     end
                  endcase
               end
               default: begin
                  ILLEGAL  = 1'b1;
                  PC_WRITE = 1'b1;
               end
            endcase
         end
         ST_WB: begin
            MEM_RDEN2 = 1'b1;
            REG_WRITE = cnt_last;
            PC_WRITE  = cnt_last;
         end
         ST_INTR: begin
            INT_TAKEN = 1'b1;
            PC_WRITE  = 1'b1;
            IRQ_ACK   = NUM_IRQ'(1) << win_id;
            IRQ_ID    = win_id;
         end
         default: ;
      endcase
   end

endmodule
